mux_4_1_rr: RTL

MUX_4_1_RR -- requirements
Module: mux_4_1_rr

---
 rtl/mux_pkg.sv | 16 +
 rtl/rr_arb_4.sv | 38 +++
 rtl/mux_4_1_rr.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 round-robin output mux and its arbiter.
// Optional feature macro used by mux_4_1_rr: MUX_4_1_LOCK_EN (packet lock).
package mux_pkg;

    localparam int NUM_CH     = 4;
    localparam int DATA_W_DEF = 8;

    // Channel index, wide enough for NUM_CH; wraps naturally modulo 4.
    typedef logic [1:0] ch_idx_t;

    // Channel that follows c in round-robin order (3 wraps to 0).
    function automatic ch_idx_t next_ch(input ch_idx_t c);
        return c + ch_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_arb_4.sv
// Four-way round-robin winner search: scans ptr, ptr+1, ptr+2, ptr+3 (mod 4)
// and returns the first requesting channel as a one-hot grant plus its index.
// Purely combinational; the caller owns the pointer register.
module rr_arb_4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           ptr,
    output logic [NUM_CH-1:0] grant,
    output ch_idx_t           idx
);

    // Candidate channel at each search position, rotated by the pointer.
    ch_idx_t cand [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand[gi] = ptr + ch_idx_t'(gi);
        end
    endgenerate

    // Take the first requesting candidate in search order.
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        idx   = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && req[cand[k]]) begin
                found          = 1'b1;
                grant[cand[k]] = 1'b1;
                idx            = cand[k];
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr.sv
// 4:1 round-robin mux with a single registered output slot.
// Optional feature macro: MUX_4_1_LOCK_EN -- once a channel is granted with
// in_last low, only that channel is eligible until its in_last word moves.
module mux_4_1_rr
    import mux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output ch_idx_t                  out_sel,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    ch_idx_t           out_sel_q,   out_sel_d;
    ch_idx_t           ptr_q,       ptr_d;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant_oh;
    ch_idx_t           grant_idx;
    logic              can_load;
    logic              do_grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The slot accepts a new word when empty or when its word leaves this cycle.
    assign can_load = !out_valid_q || out_ready;

`ifdef MUX_4_1_LOCK_EN
    logic    locked_q, locked_d;
    ch_idx_t lock_ch_q, lock_ch_d;

    // While locked, mask every channel except the locked one.
    assign eligible = locked_q ? (in_valid & (NUM_CH'(1) << lock_ch_q)) : in_valid;
`else
    // in_last has no meaning without packet locking; fold it into a sink.
    logic unused_last;
    assign unused_last = ^in_last;
    assign eligible    = in_valid;
`endif

    rr_arb_4 u_arb (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (grant_oh),
        .idx   (grant_idx)
    );

    assign do_grant = can_load && (|grant_oh);
    assign in_ready = (rst || !can_load) ? '0 : grant_oh;

    // Next-state for the slot, pointer and (optionally) lock.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef MUX_4_1_LOCK_EN
        locked_d    = locked_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (do_grant) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[grant_idx];
            out_sel_d   = grant_idx;
            ptr_d       = next_ch(grant_idx);
`ifdef MUX_4_1_LOCK_EN
            locked_d    = !in_last[grant_idx];
            lock_ch_d   = grant_idx;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held word and restarts the search at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef MUX_4_1_LOCK_EN
            locked_q    <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef MUX_4_1_LOCK_EN
            locked_q    <= locked_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
